// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the EX/MEM stage and a handshake memory port.
// Runs each load/store through IDLE -> BUSY -> DONE, stalling the pipeline until the access finishes.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        err_clr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [1:0]  err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        start;
    logic [1:0]  err_set;

    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        rdata_d     = rdata_q;
        is_read_d   = is_read_q;
        tcnt_d      = tcnt_q;
        err_set     = 2'b00;
        stall       = 1'b0;
        start       = (mem_read | mem_write) & ~flush;

        case (state_q)
            IDLE: begin
                if (start) begin
                    stall      = 1'b1;
                    state_d    = BUSY;
                    dm_req_d   = 1'b1;
                    dm_we_d    = mem_write & ~mem_read;
                    dm_addr_d  = addr;
                    dm_wdata_d = wdata;
                    is_read_d  = mem_read;
                    tcnt_d     = 8'd0;
                    err_set[1] = mem_read & mem_write;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (dm_ack) begin
                    state_d  = DONE;
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    if (is_read_q) begin
                        rdata_d = dm_rdata;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d    = DONE;
                    dm_req_d   = 1'b0;
                    dm_we_d    = 1'b0;
                    rdata_d    = 32'd0;
                    err_set[0] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d       = (err_q & ~{2{err_clr}}) | err_set;
        stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= 32'd0;
            dm_wdata_q  <= 32'd0;
            rdata_q     <= 32'd0;
            is_read_q   <= 1'b0;
            err_q       <= 2'b00;
            stall_cnt_q <= 16'd0;
            tcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            rdata_q     <= rdata_d;
            is_read_q   <= is_read_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == DONE) && is_read_q;
    assign err         = err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of BUSY cycles to wait for mem_ack (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port mem_read, input, 1, load request from the EX/MEM stage.
REQ-005 SHALL have port mem_write, input, 1, store request from the EX/MEM stage.
REQ-006 SHALL have port addr, input, 32, EX/MEM ALU result used as the byte address.
REQ-007 SHALL have port wdata, input, 32, EX/MEM store data.
REQ-008 SHALL have port flush, input, 1, meaning the current EX/MEM instruction is squashed.
REQ-009 SHALL have port err_clr, input, 1, which clears the sticky error bits.
REQ-010 SHALL have ports dm_req (output, 1), dm_we (output, 1), dm_addr (output, 32) and dm_wdata (output, 32), the memory request channel.
REQ-011 SHALL have ports dm_ack (input, 1) and dm_rdata (input, 32), the memory response.
REQ-012 SHALL have port stall, output, 1, which freezes the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 SHALL have ports rdata (output, 32) and rdata_valid (output, 1), the load result for MEM/WB.
REQ-014 SHALL have port err, output, 2: bit0 timeout, bit1 read/write conflict; both bits sticky.
REQ-015 SHALL have port stall_cnt, output, 16, a saturating count of stall cycles.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-017 IDLE: the block SHALL start an access when (mem_read|mem_write)&~flush; otherwise it SHALL remain in IDLE.
REQ-018 On start, the block SHALL go to BUSY next cycle, with dm_addr/dm_wdata registered from addr/wdata, dm_we=mem_write&~mem_read, dm_req=1 and the timeout counter cleared.
REQ-019 If mem_read and mem_write are both 1 at start, the block SHALL perform a read and set err[1].
REQ-020 stall SHALL be combinational: 1 in IDLE while a start condition holds, 1 throughout BUSY, 0 in DONE.
REQ-021 BUSY: dm_req, dm_we, dm_addr and dm_wdata SHALL be held stable until dm_ack or timeout.
REQ-022 On dm_ack in BUSY, the block SHALL deassert dm_req next cycle, go to DONE, and latch rdata=dm_rdata if the access was a read (rdata unchanged for a write).
REQ-023 The timeout counter SHALL increment each BUSY cycle without dm_ack.
REQ-024 When the counter reaches TIMEOUT-1 with no ack, the block SHALL deassert dm_req, set err[0], set rdata=0 and go to DONE.
REQ-025 dm_ack and timeout in the same cycle SHALL count as an ack; err[0] is not set.
REQ-026 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; mem_read/mem_write in DONE SHALL be ignored, since they still reflect the completed instruction.
REQ-027 rdata_valid SHALL be 1 only in DONE of a read access (including a timed-out read).
REQ-028 flush SHALL have effect only in IDLE; a BUSY transaction SHALL always complete.
REQ-029 dm_ack outside BUSY SHALL be ignored.
REQ-030 The minimum access is 3 cycles (IDLE-start, BUSY with ack, DONE), and back-to-back accesses SHALL restart from IDLE.
REQ-031 stall_cnt SHALL increment each cycle stall=1 and saturate at 16'hFFFF.
REQ-032 err bits SHALL be set-dominant: a set event in the same cycle as err_clr leaves the bit 1.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, rdata=0, rdata_valid=0, err=0, stall_cnt=0 and timeout counter=0, regardless of clk.
REQ-034 Reset asserted during BUSY SHALL abandon the transaction; dm_req drops asynchronously.
REQ-035 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-036 Load: mem_read=1, addr=0x100, dm_ack on the 2nd BUSY cycle with dm_rdata=0xCAFE0001 -> stall high for 3 cycles, then DONE with rdata=0xCAFE0001, rdata_valid=1, stall_cnt=3.
REQ-037 Store: mem_write=1, addr=0x20, wdata=0x55AA55AA, dm_ack immediately -> dm_we=1 and dm_addr=0x20 for 1 BUSY cycle, rdata_valid=0 in DONE.
REQ-038 Timeout: TIMEOUT=4, read, no ack -> dm_req high for exactly 4 cycles, err=2'b01, rdata=0, rdata_valid=1; err_clr -> err=0.
REQ-039 Conflict and flush: mem_read=mem_write=1 -> dm_we=0, err[1]=1; mem_read=1 with flush=1 -> no dm_req, stall=0.
REQ-040 Reset mid-BUSY: rst_n low between edges -> dm_req=0 and stall=0 before the next edge; stall_cnt=0.
REQ-041 Back-to-back loads with ack every BUSY cycle -> each load takes 3 cycles, no request issued during DONE, stall_cnt saturates at 0xFFFF under a stalled memory.
